timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter: Bits, default 4, width of count, limit and Q.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset; forces the reset state immediately, independent of clk.
REQ-004 start  input  1  request to begin a count sequence; sampled only in IDLE.
REQ-005 stop  input  1  abort request; sampled in every state; highest priority after reset.
REQ-006 en  input  1  count enable; in RUN, Q advances only on cycles with en=1.
REQ-007 dir  input  1  0 = up count 0->limit, 1 = down count limit->0; sampled with start.
REQ-008 auto_reload  input  1  0 = one-shot, 1 = periodic; sampled with start.
REQ-009 load_val  input  Bits  terminal/start value (limit); sampled with start.
REQ-010 Q  output  Bits  current count, registered.
REQ-011 busy  output  1  high while in RUN, registered.
REQ-012 done  output  1  one-cycle pulse per completed sequence, registered.

Function
REQ-013 The FSM SHALL have two states, IDLE and RUN, plus internal registers limit, dir_r and mode_r (Bits+2 flops).
REQ-014 IDLE, start=1, stop=0 at an edge: after that edge, state=RUN, busy=1, limit=load_val, dir_r=dir, mode_r=auto_reload, Q = 0 (dir=0) or load_val (dir=1).
REQ-015 IDLE, start=0 or stop=1: Q, busy=0 and limit SHALL hold; done=0.
REQ-016 Terminal value SHALL be limit for up and 0 for down.
REQ-017 RUN, stop=0, en=1, Q != terminal: Q SHALL become Q+1 (up) or Q-1 (down), modulo 2^Bits, no overflow flag.
REQ-018 RUN, stop=0, en=1, Q == terminal, mode_r=0: after the edge, state=IDLE, busy=0, done=1, Q holds terminal.
REQ-019 RUN, stop=0, en=1, Q == terminal, mode_r=1: after the edge, state stays RUN, busy=1, done=1, Q reloads the start value (0 up, limit down).
REQ-020 RUN, en=0, stop=0: Q, state, busy SHALL hold; done=0, including when Q == terminal.
REQ-021 stop=1 in RUN: after the edge, state=IDLE, busy=0, done=0, Q holds its current value; stop overrides a simultaneous terminal event (no done).
REQ-022 start in RUN SHALL be ignored; load_val, dir, auto_reload changes in RUN SHALL have no effect.
REQ-023 done SHALL be 1 for exactly one cycle per terminal event and 0 otherwise.
REQ-024 With en held high, a one-shot sequence SHALL keep busy high for limit+1 cycles; an auto-reload period SHALL be limit+1 cycles.
REQ-025 limit=0: the first enabled RUN cycle SHALL be terminal (one-shot: done after 1 cycle; auto-reload: done every enabled cycle).
REQ-026 A new start SHALL be accepted in the cycle immediately after a one-shot done (back-to-back sequences).

Reset
REQ-027 reset=1 SHALL asynchronously force state=IDLE, Q=0, busy=0, done=0, limit=0, dir_r=0, mode_r=0.
REQ-028 Reset asserted mid-RUN SHALL abort without a done pulse; after deassertion the block SHALL wait in IDLE for start.
REQ-029 Deassertion SHALL be the only exit from reset; no input is sampled while reset=1.

Verification (Bits=4)
REQ-030 Up one-shot: load_val=5, dir=0, auto_reload=0, start 1 cycle, en=1 -> Q 0,1,2,3,4,5; done=1 one cycle as busy falls; Q stays 5.
REQ-031 Down auto-reload: load_val=3, dir=1, auto_reload=1, en=1 -> Q 3,2,1,0,3,2,...; done pulse each reload; busy stays 1.
REQ-032 Enable gating: up, load_val=4, en toggled 1/0 -> Q advances only on en=1 cycles; en=0 at Q=4 -> no done until en=1.
REQ-033 Stop priority: up, load_val=2, stop=1 on the cycle Q=2 with en=1 -> IDLE, busy=0, done never asserts, Q=2.
REQ-034 Edge cases: load_val=0 one-shot -> done after 1 RUN cycle; load_val=15 up -> Q reaches 15, done, no wrap; start during RUN ignored.
REQ-035 Async reset: reset pulsed between clock edges mid-RUN at Q=7 -> Q=0, busy=0, done=0 immediately; next start with load_val=1 behaves per REQ-014.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// rtl/timer_ctrl_if.sv - control/status bundle between a timer host and timer_ctrl
interface timer_ctrl_if #(
    parameter int Bits = 4
);
    logic            start;
    logic            stop;
    logic            en;
    logic            dir;
    logic            auto_reload;
    logic [Bits-1:0] load_val;
    logic [Bits-1:0] Q;
    logic            busy;
    logic            done;

    modport master (
        output start, stop, en, dir, auto_reload, load_val,
        input  Q, busy, done
    );

    modport slave (
        input  start, stop, en, dir, auto_reload, load_val,
        output Q, busy, done
    );
endinterface

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - up/down one-shot or periodic counter with start/stop/enable control
module timer_ctrl #(
    parameter int Bits = 4
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [Bits-1:0] ZERO = '0;
    localparam logic [Bits-1:0] ONE  = {{(Bits-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [Bits-1:0] count_q, count_d;
    logic [Bits-1:0] limit_q, limit_d;
    logic            dir_q, dir_d;
    logic            mode_q, mode_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [Bits-1:0] terminal;

    // Up counts end at the captured limit, down counts end at zero.
    assign terminal = dir_q ? ZERO : limit_q;

    // State register; reset aborts immediately with no done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: stop beats everything, then start (IDLE) or counting (RUN).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start && !bus.stop) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    limit_d = bus.load_val;
                    dir_d   = bus.dir;
                    mode_d  = bus.auto_reload;
                    count_d = bus.dir ? bus.load_val : ZERO;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (bus.en) begin
                    if (count_q == terminal) begin
                        done_d = 1'b1;
                        if (mode_q) begin
                            // Periodic: restart from the start value, stay busy.
                            count_d = dir_q ? limit_q : ZERO;
                        end else begin
                            // One-shot: leave Q parked on the terminal value.
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        count_d = dir_q ? (count_q - ONE) : (count_q + ONE);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.Q    = count_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - randomized and directed self-checking bench for timer_ctrl
module tb_timer_ctrl;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    timer_ctrl_if #(.Bits(4)) bus ();

    timer_ctrl #(.Bits(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a sequence is a walk of position 0..limit; Q is that position
    // seen from the chosen end (pos for up, limit-pos for down).
    bit m_run  = 0;
    int m_pos  = 0;
    int m_lim  = 0;
    bit m_dir  = 0;
    bit m_mode = 0;
    bit m_done = 0;

    function automatic int model_q();
        return m_dir ? (m_lim - m_pos) : m_pos;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on the same edges the DUT sees.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 0; m_pos = 0; m_lim = 0; m_dir = 0; m_mode = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_run) begin
                if (bus.start && !bus.stop) begin
                    m_run  = 1;
                    m_lim  = int'(bus.load_val);
                    m_dir  = bus.dir;
                    m_mode = bus.auto_reload;
                    m_pos  = 0;
                end
            end else if (bus.stop) begin
                m_run = 0;
            end else if (bus.en) begin
                if (m_pos == m_lim) begin
                    m_done = 1;
                    if (m_mode) m_pos = 0;
                    else        m_run = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
    end

    // Compare outputs against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("model_Q",    int'(bus.Q),    model_q());
            chk("model_busy", int'(bus.busy), int'(m_run));
            chk("model_done", int'(bus.done), int'(m_done));
        end
    end

    task automatic drive(input bit st, input bit sp, input bit e, input bit d,
                         input bit ar, input int lv);
        bus.start       = st;
        bus.stop        = sp;
        bus.en          = e;
        bus.dir         = d;
        bus.auto_reload = ar;
        bus.load_val    = 4'(lv);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_Q", int'(bus.Q), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Up one-shot, limit 5.
        drive(1, 0, 1, 0, 0, 5);
        tick();
        drive(0, 0, 1, 0, 0, 5);
        chk("up_start_Q", int'(bus.Q), 0);
        chk("up_start_busy", int'(bus.busy), 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("up_Q", int'(bus.Q), i);
        end
        chk("up_pre_done", int'(bus.done), 0);
        tick();
        chk("up_done", int'(bus.done), 1);
        chk("up_busy_fall", int'(bus.busy), 0);
        chk("up_hold_Q", int'(bus.Q), 5);
        tick();
        chk("up_done_pulse", int'(bus.done), 0);

        // Down auto-reload, limit 3.
        drive(1, 0, 1, 1, 1, 3);
        tick();
        drive(0, 0, 1, 1, 1, 3);
        chk("dn_start_Q", int'(bus.Q), 3);
        tick(); chk("dn_Q2", int'(bus.Q), 2);
        tick(); chk("dn_Q1", int'(bus.Q), 1);
        tick(); chk("dn_Q0", int'(bus.Q), 0);
        tick();
        chk("dn_reload_Q", int'(bus.Q), 3);
        chk("dn_reload_done", int'(bus.done), 1);
        chk("dn_reload_busy", int'(bus.busy), 1);
        drive(0, 1, 1, 1, 1, 3);
        tick();
        drive(0, 0, 0, 0, 0, 0);

        // Stop on the terminal cycle wins over done.
        drive(1, 0, 1, 0, 0, 2);
        tick();
        drive(0, 0, 1, 0, 0, 2);
        tick(); tick();
        chk("stop_pre_Q", int'(bus.Q), 2);
        drive(0, 1, 1, 0, 0, 2);
        tick();
        drive(0, 0, 1, 0, 0, 2);
        chk("stop_busy", int'(bus.busy), 0);
        chk("stop_done", int'(bus.done), 0);
        chk("stop_Q", int'(bus.Q), 2);
        tick();
        chk("stop_done_after", int'(bus.done), 0);

        // Limit 0 one-shot, then back-to-back start with limit 1.
        drive(1, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        chk("z_busy", int'(bus.busy), 1);
        tick();
        chk("z_done", int'(bus.done), 1);
        drive(1, 0, 1, 0, 0, 1);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        chk("b2b_busy", int'(bus.busy), 1);
        chk("b2b_Q", int'(bus.Q), 0);
        tick(); tick();
        chk("b2b_done", int'(bus.done), 1);

        // Limit 15 up with a start attempt mid-run.
        drive(1, 0, 1, 0, 0, 15);
        tick();
        for (int i = 1; i <= 15; i++) begin
            drive((i == 4), 0, 1, (i == 4), 0, (i == 4) ? 3 : 0);
            tick();
            chk("max_Q", int'(bus.Q), i);
        end
        tick();
        chk("max_done", int'(bus.done), 1);
        chk("max_Q_nowrap", int'(bus.Q), 15);

        // Enable gating with en low on the terminal value.
        drive(1, 0, 0, 0, 0, 4);
        tick();
        drive(0, 0, 1, 0, 0, 4); tick(); chk("en_Q1", int'(bus.Q), 1);
        drive(0, 0, 0, 0, 0, 4); tick(); chk("en_hold", int'(bus.Q), 1);
        drive(0, 0, 1, 0, 0, 4); tick(); tick(); tick(); chk("en_Q4", int'(bus.Q), 4);
        drive(0, 0, 0, 0, 0, 4);
        repeat (3) begin
            tick();
            chk("en_term_nodone", int'(bus.done), 0);
            chk("en_term_busy", int'(bus.busy), 1);
        end
        drive(0, 0, 1, 0, 0, 4); tick();
        chk("en_term_done", int'(bus.done), 1);

        // Async reset mid-run at Q=7.
        drive(1, 0, 1, 0, 0, 10);
        tick();
        drive(0, 0, 1, 0, 0, 10);
        repeat (7) tick();
        chk("ar_pre_Q", int'(bus.Q), 7);
        #2 reset = 1'b1;
        #1;
        chk("ar_Q", int'(bus.Q), 0);
        chk("ar_busy", int'(bus.busy), 0);
        chk("ar_done", int'(bus.done), 0);
        #1 reset = 1'b0;
        drive(1, 0, 1, 0, 0, 1);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        chk("ar_restart_Q", int'(bus.Q), 0);
        chk("ar_restart_busy", int'(bus.busy), 1);
        tick(); tick();
        chk("ar_restart_done", int'(bus.done), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
                  1'($urandom), 1'($urandom), int'($urandom_range(15)));
            tick();
        end

        drive(0, 0, 0, 0, 0, 0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
